// File: rtl/rep_pixel_pkg.sv
// Shared types and helpers for the nearest-neighbour pixel upscaler.
package rep_pixel_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  // Out-of-range factors fall back to plain pass-through.
  function automatic int unsigned fator_coerce(input int unsigned f, input int unsigned fmax);
    return ((f == 0) || (f > fmax)) ? 1 : f;
  endfunction

endpackage

// File: rtl/rep_linha_buf.sv
// One-row line buffer: simple dual-port RAM, synchronous write, 1-cycle registered read.
module rep_linha_buf #(
  parameter int LARGURA = 160,
  parameter int DATA_W  = 8,
  parameter int AW      = (LARGURA > 1) ? $clog2(LARGURA) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LARGURA];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rep_pixel_stream.sv
// Streaming nearest-neighbour upscaler: buffers one row, emits it F times with each pixel repeated F times.
// Optional frame counter output `quadros` is enabled with REP_PIXEL_CONT_EN.
module rep_pixel_stream
  import rep_pixel_pkg::*;
#(
  parameter int LARGURA   = 160,
  parameter int ALTURA    = 120,
  parameter int DATA_W    = 8,
  parameter int FATOR_MAX = 4,
  parameter int FW        = $clog2(FATOR_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FW-1:0]     fator,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              busy,
`ifdef REP_PIXEL_CONT_EN
  output logic [15:0]       quadros,
`endif
  output logic              frame_done
);

  localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int RW = (ALTURA > 1) ? $clog2(ALTURA) : 1;
  localparam int SW = (FATOR_MAX > 1) ? $clog2(FATOR_MAX) : 1;

  state_t            state_q, state_d;
  logic [SW-1:0]     fm1_q, fm1_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SW-1:0]     sub_q, sub_d;
  logic [SW-1:0]     rep_q, rep_d;
  logic [RW-1:0]     row_q, row_d;
  logic              issued_q, issued_d;
  logic              in_ready_q, in_ready_d;
  logic              frame_done_q, frame_done_d;
  logic              vld_p0_q, vld_p0_d;
  logic              sof_p0_q, sof_p0_d;
  logic              eol_p0_q, eol_p0_d;
  logic              last_p0_q, last_p0_d;
  logic              vld_p1_q, vld_p1_d;
  logic              sof_p1_q, sof_p1_d;
  logic              eol_p1_q, eol_p1_d;
  logic              last_p1_q, last_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;

  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              out_adv, issue;
  logic              last_col, last_sub, last_rep;

  rep_linha_buf #(.LARGURA(LARGURA), .DATA_W(DATA_W), .AW(CW)) u_buf (
    .clk   (clk),
    .we    (ram_we),
    .waddr (col_q),
    .wdata (in_data),
    .re    (ram_re),
    .raddr (col_q),
    .rdata (ram_rdata)
  );

  assign out_adv  = !vld_p1_q || out_ready;
  assign last_col = (col_q == CW'(LARGURA - 1));
  assign last_sub = (sub_q == fm1_q);
  assign last_rep = (rep_q == fm1_q);

  always_comb begin
    state_d      = state_q;
    fm1_d        = fm1_q;
    col_d        = col_q;
    sub_d        = sub_q;
    rep_d        = rep_q;
    row_d        = row_q;
    issued_d     = issued_q;
    in_ready_d   = in_ready_q;
    frame_done_d = 1'b0;
    vld_p0_d     = vld_p0_q;
    sof_p0_d     = sof_p0_q;
    eol_p0_d     = eol_p0_q;
    last_p0_d    = last_p0_q;
    vld_p1_d     = vld_p1_q;
    sof_p1_d     = sof_p1_q;
    eol_p1_d     = eol_p1_q;
    last_p1_d    = last_p1_q;
    data_p1_d    = data_p1_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    issue        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          fm1_d      = SW'(fator_coerce(32'(fator), 32'(FATOR_MAX)) - 1);
          col_d      = '0;
          sub_d      = '0;
          rep_d      = '0;
          row_d      = '0;
          issued_d   = 1'b0;
          in_ready_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          ram_we = 1'b1;
          if (last_col) begin
            col_d      = '0;
            sub_d      = '0;
            rep_d      = '0;
            issued_d   = 1'b0;
            in_ready_d = 1'b0;
            state_d    = EMIT;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      EMIT: begin
        // p0 -> p1: RAM read result moves into the output register
        if (out_adv) begin
          vld_p1_d  = vld_p0_q;
          sof_p1_d  = vld_p0_q && sof_p0_q;
          eol_p1_d  = vld_p0_q && eol_p0_q;
          last_p1_d = vld_p0_q && last_p0_q;
          if (vld_p0_q) data_p1_d = ram_rdata;
          vld_p0_d  = 1'b0;
        end
        // issue -> p0: a read may refill p0 whenever p0 is empty or draining
        issue = !issued_q && (!vld_p0_q || out_adv);
        if (issue) begin
          ram_re    = 1'b1;
          vld_p0_d  = 1'b1;
          sof_p0_d  = (row_q == '0) && (rep_q == '0) && (col_q == '0) && (sub_q == '0);
          eol_p0_d  = last_col && last_sub;
          last_p0_d = last_col && last_sub && last_rep;
          if (last_sub) begin
            sub_d = '0;
            if (last_col) begin
              col_d = '0;
              if (last_rep) begin
                rep_d    = '0;
                issued_d = 1'b1;
              end else begin
                rep_d = rep_q + SW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
        if (vld_p1_q && out_ready && last_p1_q) begin
          if (row_q == RW'(ALTURA - 1)) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            row_d      = row_q + RW'(1);
            in_ready_d = 1'b1;
            state_d    = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fm1_q        <= '0;
      col_q        <= '0;
      sub_q        <= '0;
      rep_q        <= '0;
      row_q        <= '0;
      issued_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      vld_p0_q     <= 1'b0;
      sof_p0_q     <= 1'b0;
      eol_p0_q     <= 1'b0;
      last_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      sof_p1_q     <= 1'b0;
      eol_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      data_p1_q    <= '0;
    end else begin
      state_q      <= state_d;
      fm1_q        <= fm1_d;
      col_q        <= col_d;
      sub_q        <= sub_d;
      rep_q        <= rep_d;
      row_q        <= row_d;
      issued_q     <= issued_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
      vld_p0_q     <= vld_p0_d;
      sof_p0_q     <= sof_p0_d;
      eol_p0_q     <= eol_p0_d;
      last_p0_q    <= last_p0_d;
      vld_p1_q     <= vld_p1_d;
      sof_p1_q     <= sof_p1_d;
      eol_p1_q     <= eol_p1_d;
      last_p1_q    <= last_p1_d;
      data_p1_q    <= data_p1_d;
    end
  end

`ifdef REP_PIXEL_CONT_EN
  logic [15:0] quadros_q, quadros_d;

  always_comb begin
    quadros_d = quadros_q + 16'(frame_done_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) quadros_q <= '0;
    else        quadros_q <= quadros_d;
  end

  assign quadros = quadros_q;
`endif

  assign in_ready   = in_ready_q;
  assign out_valid  = vld_p1_q;
  assign out_data   = data_p1_q;
  assign out_sof    = sof_p1_q;
  assign out_eol    = eol_p1_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/rep_pixel_stream.md
# rep_pixel_stream

Streaming nearest-neighbour upscaler for 8-bit (parametrisable) grayscale frames. Accepts one raster-order input frame over a valid/ready stream, buffers one input row, and emits each row `fator` times with each pixel repeated `fator` times. The factor is selectable at run time, up to `FATOR_MAX`. Sits between the frame-memory reader and the VGA output framebuffer writer.

## Interface
- `LARGURA`, 160: input frame width in pixels
- `ALTURA`, 120: input frame height in rows
- `DATA_W`, 8: pixel width in bits
- `FATOR_MAX`, 4: largest supported replication factor (≥1)
- `FW`, $clog2(FATOR_MAX+1): width of `fator`
- `clk`  in  1  single system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  pulse in IDLE to begin a frame
- `fator`  in  FW  replication factor, sampled on accepted `start`
- `in_valid`  in  1  input pixel valid
- `in_ready`  out  1  block accepts input pixel
- `in_data`  in  DATA_W  input pixel
- `out_valid`  out  1  output pixel valid
- `out_ready`  in  1  downstream accepts output pixel
- `out_data`  out  DATA_W  output pixel
- `out_sof`  out  1  qualifies first output pixel of frame
- `out_eol`  out  1  qualifies last output pixel of each output row
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse after last output pixel handshake

## Operation
- FSM states: IDLE, LOAD, EMIT, DONE.
- IDLE: `start`=1 latches factor F; F=0 or F>FATOR_MAX is coerced to 1. Row/column counters cleared; go to LOAD. `start` outside IDLE is ignored.
- LOAD: `in_ready`=1. Each `in_valid&in_ready` writes `in_data` to line buffer at column index. After column LARGURA-1 is written, go to EMIT.
- EMIT: `in_ready`=0. Reads line buffer. Emits pixel col c for sub-column 0..F-1, c=0..LARGURA-1, giving one output row of LARGURA·F pixels. Repeats for replica 0..F-1. After the last replica: if the input row is ALTURA-1, go to DONE; else go to LOAD for next row.
- DONE: `frame_done`=1 for one cycle, then go to IDLE.
- Frame total: LARGURA·ALTURA·F² output pixels, (LARGURA·F) per output row, ALTURA·F output rows.
- `out_sof`=1 only on pixel (row 0, replica 0, col 0, sub 0). `out_eol`=1 on col LARGURA-1, sub F-1 of every replica.
- Counter widths: $clog2 of each bound, minimum 1 bit. There is no arithmetic overflow; counters compare against bounds and never wrap.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sof`=0, `out_eol`=0, `busy`=0, `frame_done`=0, state IDLE. Line buffer contents are not reset.
- Reset asserted mid-frame aborts the frame immediately. No `frame_done` is produced. The next `start` begins a clean frame.
- `start` accepted at edge N: `in_ready`=1 from edge N+1.
- Line buffer read latency is 1 cycle. First `out_valid` of a row appears 2 cycles after the last LOAD handshake.
- `out_data`, `out_sof` and `out_eol` are registered. While `out_valid&!out_ready`, all three stay stable and `out_valid` stays high. `out_valid` never drops without a handshake.
- With `out_ready` held at 1, EMIT sustains one pixel per cycle, including across replica boundaries. No bubbles are allowed within a row set.
- `fator` changes after `start` have no effect until the next frame.
- `frame_done` is asserted the cycle after the final output handshake.

## Configuration
- `REP_PIXEL_CONT_EN` defined: adds output port `quadros` (16 bits, reset 0). It increments on every `frame_done` and wraps from 0xFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `rep_pixel_pkg`: FSM state enum (IDLE/LOAD/EMIT/DONE) and the `fator` coercion function.
- Sub-module `rep_linha_buf`: simple dual-port RAM, LARGURA×DATA_W, with synchronous write and synchronous 1-cycle read. The FSM, counters and output register stay in `rep_pixel_stream`.

## Test plan
Use LARGURA=4, ALTURA=2, FATOR_MAX=4 unless noted.
- F=2, rows {10,11,12,13},{20,21,22,23}, `out_ready`=1 -> 32 outputs: 10,10,11,11,12,12,13,13 twice, then 20,20,…,23,23 twice. `out_sof` on output 0; `out_eol` on outputs 7, 15, 23, 31; one `frame_done` pulse.
- F=1 -> 8 outputs identical to the input order; F=4 -> 128 outputs, each input pixel appearing in a 4×4 block.
- `fator`=0 and `fator`=7 (FW=3) -> both behave as F=1 (8 outputs).
- F=2 with `out_ready` toggled randomly -> exact 32-pixel sequence, no loss or duplication; `out_data` stable during stalls.
- Reset pulsed mid-EMIT -> all outputs 0 next cycle and no `frame_done`. A following `start` with F=2 produces a correct full frame.
- `fator` changed 1→4 during LOAD of a F=2 frame -> frame completes as F=2. With `REP_PIXEL_CONT_EN`, `quadros` reads 1 after the first frame and 2 after the second.
